// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port packet arbiter.
// Holds the FSM state encoding and the round-robin pick function.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  // Widest request vector rr_pick can scan; callers zero-extend into it.
  localparam int unsigned RR_MAX = 32;

  // Index of the first set bit at or after ptr, wrapping modulo n; 0 if none.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned result;
    logic        found;
    result = 0;
    found  = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = (ptr + k) % n;
      if ((k < n) && !found && req[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin priority pick with a registered pointer; the pointer moves
// to one past the winner whenever the owner signals completion.
module rr_arbiter_core
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       upd,
  input  logic [$clog2(NUM_REQ)-1:0] upd_id,
  output logic [$clog2(NUM_REQ)-1:0] pick
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   rr_ptr;
  logic [RR_MAX-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick = ID_W'(rr_pick(req_ext, 32'(rr_ptr), NUM_REQ));
  end

  // NUM_REQ is a power of two, so the increment wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (upd) begin
      rr_ptr <= upd_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_pkt_arbiter.sv
// Round-robin whole-packet arbiter sharing one FIFO write port; a packet is
// granted only when the FIFO water level shows room for all of its words.
module fifo_wr_pkt_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 9,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                       wr_clk,
  input  logic                       wrst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  src_data,
  output logic [NUM_REQ-1:0]         src_ready,
  output logic [NUM_REQ-1:0]         req_gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       fifo_w_en,
  output logic [DATA_W-1:0]          fifo_wdata,
  input  logic                       wfull,
  input  logic [DEPTH:0]             wr_water_level,
  output logic                       busy,
  output logic                       pkt_done
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  cand, gnt_id_q, pick;
  logic [LEN_W-1:0] cnt, cand_len;
  logic [DEPTH:0]   free_words, need_words;
  logic             space_ok, cand_req, src_valid_g, wr_fire, last_word;
  logic             grant_now;
  logic [DATA_W-1:0] src_data_g;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk    (wr_clk),
    .rst    (wrst),
    .req    (req),
    .upd    (last_word),
    .upd_id (gnt_id_q),
    .pick   (pick)
  );

  // Candidate-side and granted-side muxes.
  always_comb begin
    cand_len    = '0;
    cand_req    = 1'b0;
    src_valid_g = 1'b0;
    src_data_g  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cand == ID_W'(i)) begin
        cand_len = req_len[i*LEN_W +: LEN_W];
        cand_req = req[i];
      end
      if (gnt_id_q == ID_W'(i)) begin
        src_valid_g = src_valid[i];
        src_data_g  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Level never exceeds capacity, so DEPTH+1 bits hold the difference exactly.
  always_comb begin
    free_words = {1'b1, {DEPTH{1'b0}}} - wr_water_level;
    need_words = {{(DEPTH+1-LEN_W){1'b0}}, cand_len} + (DEPTH+1)'(1);
    space_ok   = free_words >= need_words;
    grant_now  = (state == ST_ARB) && cand_req && space_ok;
    wr_fire    = (state == ST_XFER) && src_valid_g && !wfull;
    last_word  = wr_fire && (cnt == '0);
  end

  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (|req) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!cand_req)     state_nxt = ST_IDLE;
        else if (space_ok) state_nxt = ST_XFER;
      end
      ST_XFER: if (last_word) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Candidate is frozen on ARB entry so a blocked long packet keeps its turn.
  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) begin
      cand     <= '0;
      gnt_id_q <= '0;
      cnt      <= '0;
    end else begin
      if ((state == ST_IDLE) && (|req)) cand <= pick;
      if (grant_now) begin
        gnt_id_q <= cand;
        cnt      <= cand_len;
      end else if (wr_fire) begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  always_comb begin
    src_ready  = '0;
    req_gnt    = '0;
    fifo_w_en  = 1'b0;
    fifo_wdata = '0;
    pkt_done   = 1'b0;
    busy       = (state != ST_IDLE);
    gnt_id     = gnt_id_q;
    if (state == ST_XFER) begin
      req_gnt[gnt_id_q]   = 1'b1;
      src_ready[gnt_id_q] = wr_fire;
      fifo_w_en           = wr_fire;
      fifo_wdata          = src_data_g;
      pkt_done            = last_word;
    end
  end

endmodule
